// File: rtl/dffram_arbiter.sv
// -----------------------------------------------------------------------------
// dffram_arbiter
//
// Shares the single-port 256x32 management DFFRAM between the management
// core's DFF port (read/write) and the housekeeping read-only port. The core
// has priority. A starvation counter makes sure that a pending housekeeping
// read wins after at most MAX_CORE_BURST consecutive core grants.
//
// Ports:
//   core_clk, core_rstn        clock and asynchronous active-low reset
//   core_en/we/addr/wdata      core request. A stalled core holds its request.
//   core_stall                 core request not taken this cycle
//   core_rvalid, core_rdata    core read return, one cycle after the grant
//   hk_req, hk_addr            housekeeping level read request, held until ack
//   hk_ack, hk_rdata           one-cycle ack. The data stays valid until the next ack.
//   ram_en/we/a/di, ram_do     DFFRAM port. Do is valid the cycle after a read.
// -----------------------------------------------------------------------------
module dffram_arbiter #(
    parameter int AW             = 8,
    parameter int DW             = 32,
    parameter int MAX_CORE_BURST = 4
) (
    input  logic          core_clk,
    input  logic          core_rstn,
    input  logic          core_en,
    input  logic [3:0]    core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          hk_req,
    input  logic [AW-1:0] hk_addr,
    output logic          hk_ack,
    output logic [DW-1:0] hk_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HK   = 2'd1,
        OWN_CORE = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_CORE_BURST);

    owner_t        rd_owner_q, rd_owner_d;
    logic          hk_busy_q, hk_busy_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    logic [DW-1:0] hk_rdata_q, hk_rdata_d;

    logic hk_ack_int;
    logic hk_elig;
    logic hk_win;
    logic core_win;

    // The ack is decoded straight from the registered read owner. It is
    // therefore a registered pulse that occurs exactly once per housekeeping grant.
    assign hk_ack_int = (rd_owner_q == OWN_HK);

    // A request that is still held in its own ack cycle must not be re-granted.
    assign hk_elig  = hk_req & ~hk_busy_q & ~hk_ack_int;
    assign hk_win   = hk_elig & (~core_en | (starve_cnt_q == MAX_CNT));
    assign core_win = core_en & ~hk_win;

    // The combinational outputs are forced to idle while reset is asserted.
    always_comb begin
        core_stall = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 4'h0;
        ram_a      = '0;
        ram_di     = '0;
        if (core_rstn) begin
            core_stall = core_en & hk_win;
            if (hk_win) begin
                ram_en = 1'b1;
                ram_a  = hk_addr;
            end else if (core_win) begin
                ram_en = 1'b1;
                ram_we = core_we;
                ram_a  = core_addr;
                ram_di = core_wdata;
            end
        end
    end

    // The hk data is shown directly from the RAM in the ack cycle and is held
    // in a register afterwards. The caller sees the new data in the same cycle as the ack.
    assign hk_ack      = hk_ack_int;
    assign hk_rdata    = hk_ack_int ? ram_do : hk_rdata_q;
    assign core_rvalid = (rd_owner_q == OWN_CORE);
    assign core_rdata  = core_rvalid ? ram_do : '0;

    always_comb begin
        rd_owner_d   = OWN_NONE;
        hk_busy_d    = hk_busy_q;
        starve_cnt_d = starve_cnt_q;
        hk_rdata_d   = hk_rdata_q;

        if (hk_win) begin
            rd_owner_d = OWN_HK;
        end else if (core_win && (core_we == 4'h0)) begin
            rd_owner_d = OWN_CORE;
        end

        if (hk_win) begin
            hk_busy_d = 1'b1;
        end else if (hk_ack_int) begin
            hk_busy_d = 1'b0;
        end

        // The count restarts whenever the request is served or withdrawn. It
        // saturates at the burst limit, where hk_win takes over.
        if (hk_win || !hk_elig) begin
            starve_cnt_d = 4'd0;
        end else if (core_win && (starve_cnt_q != MAX_CNT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        if (hk_ack_int) begin
            hk_rdata_d = ram_do;
        end
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            rd_owner_q   <= OWN_NONE;
            hk_busy_q    <= 1'b0;
            starve_cnt_q <= 4'd0;
            hk_rdata_q   <= '0;
        end else begin
            rd_owner_q   <= rd_owner_d;
            hk_busy_q    <= hk_busy_d;
            starve_cnt_q <= starve_cnt_d;
            hk_rdata_q   <= hk_rdata_d;
        end
    end

endmodule

// File: tb/tb_dffram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dffram_arbiter
//
// Directed testbench for dffram_arbiter. It contains a behavioural 256x32
// DFFRAM with byte enables and a one-cycle read latency. Inputs are driven on
// the falling edge. All outputs are checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_dffram_arbiter;

    logic        core_clk = 1'b0;
    logic        core_rstn;
    logic        core_en;
    logic [3:0]  core_we;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        hk_req;
    logic [7:0]  hk_addr;
    logic        hk_ack;
    logic [31:0] hk_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [7:0]  ram_a;
    logic [31:0] ram_di;
    logic [31:0] ram_do;

    logic        preload;
    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 core_clk = ~core_clk;

    dffram_arbiter #(.AW(8), .DW(32), .MAX_CORE_BURST(4)) dut (
        .core_clk   (core_clk),
        .core_rstn  (core_rstn),
        .core_en    (core_en),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .hk_req     (hk_req),
        .hk_addr    (hk_addr),
        .hk_ack     (hk_ack),
        .hk_rdata   (hk_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_a      (ram_a),
        .ram_di     (ram_di),
        .ram_do     (ram_do)
    );

    // DFFRAM model. Every word is preloaded with 0x1000 + address.
    always @(posedge core_clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000 + 32'(i);
            ram_do <= 32'h0;
        end else if (ram_en) begin
            if (ram_we == 4'h0) begin
                ram_do <= mem[ram_a];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem[ram_a][b*8 +: 8] <= ram_di[b*8 +: 8];
            end
        end
    end

    task automatic drive(input logic rstn, input logic en, input logic [3:0] we,
                         input logic [7:0] addr, input logic [31:0] wd,
                         input logic hreq, input logic [7:0] haddr);
        @(negedge core_clk);
        core_rstn  = rstn;
        core_en    = en;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wd;
        hk_req     = hreq;
        hk_addr    = haddr;
        #1;
    endtask

    task automatic test_reset;
        preload = 1'b1;
        drive(1'b0, 1'b1, 4'hF, 8'h10, 32'h1234_5678, 1'b1, 8'h20);
        drive(1'b0, 1'b1, 4'hF, 8'h10, 32'h1234_5678, 1'b1, 8'h20);
        preload = 1'b0;
        n_checks++; if (ram_en !== 1'b0)      begin n_fail++; $display("FAIL rst_ram_en got=%0h exp=0", ram_en); end
        n_checks++; if (ram_we !== 4'h0)      begin n_fail++; $display("FAIL rst_ram_we got=%0h exp=0", ram_we); end
        n_checks++; if (core_stall !== 1'b0)  begin n_fail++; $display("FAIL rst_core_stall got=%0h exp=0", core_stall); end
        n_checks++; if (hk_ack !== 1'b0)      begin n_fail++; $display("FAIL rst_hk_ack got=%0h exp=0", hk_ack); end
        n_checks++; if (hk_rdata !== 32'h0)   begin n_fail++; $display("FAIL rst_hk_rdata got=%h exp=0", hk_rdata); end
        n_checks++; if (core_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_core_rvalid got=%0h exp=0", core_rvalid); end
        n_checks++; if (core_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_core_rdata got=%h exp=0", core_rdata); end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        n_checks++; if (ram_en !== 1'b0)      begin n_fail++; $display("FAIL idle_ram_en got=%0h exp=0", ram_en); end
        $display("test_reset done");
    endtask

    task automatic test_core_rw;
        drive(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF, 1'b0, 8'h00);
        n_checks++; if (ram_en !== 1'b1)         begin n_fail++; $display("FAIL wr_ram_en got=%0h exp=1", ram_en); end
        n_checks++; if (ram_we !== 4'hF)         begin n_fail++; $display("FAIL wr_ram_we got=%0h exp=f", ram_we); end
        n_checks++; if (ram_a !== 8'h10)         begin n_fail++; $display("FAIL wr_ram_a got=%h exp=10", ram_a); end
        n_checks++; if (ram_di !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_ram_di got=%h exp=deadbeef", ram_di); end
        n_checks++; if (core_stall !== 1'b0)     begin n_fail++; $display("FAIL wr_stall got=%0h exp=0", core_stall); end
        drive(1'b1, 1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h00);
        n_checks++; if (ram_we !== 4'h0)         begin n_fail++; $display("FAIL rd_ram_we got=%0h exp=0", ram_we); end
        n_checks++; if (core_rvalid !== 1'b0)    begin n_fail++; $display("FAIL wr_no_rvalid got=%0h exp=0", core_rvalid); end
        n_checks++; if (core_stall !== 1'b0)     begin n_fail++; $display("FAIL rd_stall got=%0h exp=0", core_stall); end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        n_checks++; if (core_rvalid !== 1'b1)        begin n_fail++; $display("FAIL rd_rvalid got=%0h exp=1", core_rvalid); end
        n_checks++; if (core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata got=%h exp=deadbeef", core_rdata); end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        n_checks++; if (core_rvalid !== 1'b0)        begin n_fail++; $display("FAIL rd_rvalid_drop got=%0h exp=0", core_rvalid); end
        n_checks++; if (core_rdata !== 32'h0)        begin n_fail++; $display("FAIL rd_rdata_zero got=%h exp=0", core_rdata); end
        $display("test_core_rw done");
    endtask

    task automatic test_hk_read;
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10);
        n_checks++; if (ram_en !== 1'b1)      begin n_fail++; $display("FAIL hk_ram_en got=%0h exp=1", ram_en); end
        n_checks++; if (ram_a !== 8'h10)      begin n_fail++; $display("FAIL hk_ram_a got=%h exp=10", ram_a); end
        n_checks++; if (ram_we !== 4'h0)      begin n_fail++; $display("FAIL hk_ram_we got=%0h exp=0", ram_we); end
        n_checks++; if (ram_di !== 32'h0)     begin n_fail++; $display("FAIL hk_ram_di got=%h exp=0", ram_di); end
        n_checks++; if (hk_ack !== 1'b0)      begin n_fail++; $display("FAIL hk_ack_early got=%0h exp=0", hk_ack); end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10);
        n_checks++; if (hk_ack !== 1'b1)           begin n_fail++; $display("FAIL hk_ack got=%0h exp=1", hk_ack); end
        n_checks++; if (hk_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hk_rdata got=%h exp=deadbeef", hk_rdata); end
        n_checks++; if (ram_en !== 1'b0)           begin n_fail++; $display("FAIL hk_no_regrant_in_ack got=%0h exp=0", ram_en); end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10);
        n_checks++; if (hk_ack !== 1'b0)           begin n_fail++; $display("FAIL hk_ack_pulse got=%0h exp=0", hk_ack); end
        n_checks++; if (ram_en !== 1'b1)           begin n_fail++; $display("FAIL hk_regrant got=%0h exp=1", ram_en); end
        n_checks++; if (hk_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hk_rdata_hold got=%h exp=deadbeef", hk_rdata); end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        n_checks++; if (hk_ack !== 1'b1)           begin n_fail++; $display("FAIL hk_ack2 got=%0h exp=1", hk_ack); end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        n_checks++; if (hk_ack !== 1'b0)           begin n_fail++; $display("FAIL hk_ack2_drop got=%0h exp=0", hk_ack); end
        n_checks++; if (ram_en !== 1'b0)           begin n_fail++; $display("FAIL hk_idle_ram_en got=%0h exp=0", ram_en); end
        $display("test_hk_read done");
    endtask

    // The core issues reads to addresses 0..9 back to back. hk_req rises in
    // cycle 0. The hk read takes cycle 4, and the ack follows in cycle 5.
    task automatic test_starvation;
        int   k = 0;
        logic prev_grant = 1'b0;
        int   prev_addr = 0;
        logic en;
        for (int c = 0; c < 12; c++) begin
            en = (k < 10);
            drive(1'b1, en, 4'h0, 8'(k), 32'h0, (c <= 5), 8'h10);
            n_checks++; if (core_stall !== (c == 4)) begin n_fail++; $display("FAIL starve_stall c=%0d got=%0h exp=%0h", c, core_stall, (c == 4)); end
            n_checks++; if (hk_ack !== (c == 5))     begin n_fail++; $display("FAIL starve_ack c=%0d got=%0h exp=%0h", c, hk_ack, (c == 5)); end
            n_checks++; if (core_rvalid !== prev_grant) begin n_fail++; $display("FAIL starve_rvalid c=%0d got=%0h exp=%0h", c, core_rvalid, prev_grant); end
            if (prev_grant) begin
                n_checks++; if (core_rdata !== 32'h1000 + 32'(prev_addr)) begin n_fail++; $display("FAIL starve_rdata c=%0d got=%h exp=%h", c, core_rdata, 32'h1000 + 32'(prev_addr)); end
            end
            if (c == 4) begin
                n_checks++; if (ram_a !== 8'h10) begin n_fail++; $display("FAIL starve_hk_a got=%h exp=10", ram_a); end
            end else if (en) begin
                n_checks++; if (ram_a !== 8'(k)) begin n_fail++; $display("FAIL starve_core_a c=%0d got=%h exp=%h", c, ram_a, 8'(k)); end
            end
            if (c == 5) begin
                n_checks++; if (hk_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL starve_hk_rdata got=%h exp=deadbeef", hk_rdata); end
            end
            prev_grant = en && (c != 4);
            prev_addr  = k;
            if (prev_grant) k++;
        end
        $display("test_starvation done");
    endtask

    task automatic test_byte_write;
        drive(1'b1, 1'b1, 4'b0010, 8'h10, 32'h0000_AB00, 1'b0, 8'h00);
        n_checks++; if (ram_we !== 4'b0010)      begin n_fail++; $display("FAIL bw_ram_we got=%0h exp=2", ram_we); end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10);
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h10);
        n_checks++; if (hk_ack !== 1'b1)           begin n_fail++; $display("FAIL bw_ack got=%0h exp=1", hk_ack); end
        n_checks++; if (hk_rdata !== 32'hDEADABEF) begin n_fail++; $display("FAIL bw_hk_rdata got=%h exp=deadabef", hk_rdata); end
        $display("test_byte_write done");
    endtask

    task automatic test_reset_midflight;
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10);
        n_checks++; if (ram_en !== 1'b1)      begin n_fail++; $display("FAIL mr_grant got=%0h exp=1", ram_en); end
        drive(1'b0, 1'b1, 4'h0, 8'h03, 32'h0, 1'b1, 8'h10);
        n_checks++; if (hk_ack !== 1'b0)      begin n_fail++; $display("FAIL mr_hk_ack got=%0h exp=0", hk_ack); end
        n_checks++; if (hk_rdata !== 32'h0)   begin n_fail++; $display("FAIL mr_hk_rdata got=%h exp=0", hk_rdata); end
        n_checks++; if (core_rvalid !== 1'b0) begin n_fail++; $display("FAIL mr_rvalid got=%0h exp=0", core_rvalid); end
        n_checks++; if (ram_en !== 1'b0)      begin n_fail++; $display("FAIL mr_ram_en got=%0h exp=0", ram_en); end
        n_checks++; if (core_stall !== 1'b0)  begin n_fail++; $display("FAIL mr_stall got=%0h exp=0", core_stall); end
        drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10);
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10);
        n_checks++; if (ram_en !== 1'b1)      begin n_fail++; $display("FAIL mr_regrant got=%0h exp=1", ram_en); end
        n_checks++; if (ram_a !== 8'h10)      begin n_fail++; $display("FAIL mr_regrant_a got=%h exp=10", ram_a); end
        n_checks++; if (hk_ack !== 1'b0)      begin n_fail++; $display("FAIL mr_ack_early got=%0h exp=0", hk_ack); end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h10);
        n_checks++; if (hk_ack !== 1'b1)           begin n_fail++; $display("FAIL mr_ack got=%0h exp=1", hk_ack); end
        n_checks++; if (hk_rdata !== 32'hDEADABEF) begin n_fail++; $display("FAIL mr_hk_rdata2 got=%h exp=deadabef", hk_rdata); end
        $display("test_reset_midflight done");
    endtask

    // hk_req pulses in cycles 0-1 and is withdrawn. It rises again in cycle 4.
    // If the starvation count has cleared, the hk read wins in cycle 8 after
    // four core grants. No ack and no stall may come from the withdrawn request.
    task automatic test_withdraw;
        int   k = 0;
        logic prev_grant = 1'b0;
        int   prev_addr = 0;
        logic hreq;
        for (int c = 0; c < 11; c++) begin
            hreq = (c < 2) || (c >= 4 && c <= 9);
            drive(1'b1, 1'b1, 4'h0, 8'(k), 32'h0, hreq, 8'h10);
            n_checks++; if (core_stall !== (c == 8)) begin n_fail++; $display("FAIL wd_stall c=%0d got=%0h exp=%0h", c, core_stall, (c == 8)); end
            n_checks++; if (hk_ack !== (c == 9))     begin n_fail++; $display("FAIL wd_ack c=%0d got=%0h exp=%0h", c, hk_ack, (c == 9)); end
            n_checks++; if (core_rvalid !== prev_grant) begin n_fail++; $display("FAIL wd_rvalid c=%0d got=%0h exp=%0h", c, core_rvalid, prev_grant); end
            if (prev_grant) begin
                n_checks++; if (core_rdata !== 32'h1000 + 32'(prev_addr)) begin n_fail++; $display("FAIL wd_rdata c=%0d got=%h exp=%h", c, core_rdata, 32'h1000 + 32'(prev_addr)); end
            end
            if (c == 9) begin
                n_checks++; if (hk_rdata !== 32'hDEADABEF) begin n_fail++; $display("FAIL wd_hk_rdata got=%h exp=deadabef", hk_rdata); end
            end
            prev_grant = (c != 8);
            prev_addr  = k;
            if (prev_grant) k++;
        end
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        $display("test_withdraw done");
    endtask

    initial begin
        core_rstn = 1'b0; core_en = 1'b0; core_we = 4'h0; core_addr = 8'h0;
        core_wdata = 32'h0; hk_req = 1'b0; hk_addr = 8'h0; preload = 1'b1;
        test_reset;
        test_core_rw;
        test_hk_read;
        test_starvation;
        test_byte_write;
        test_reset_midflight;
        test_withdraw;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dffram_arbiter.md
Name: dffram_arbiter

Overview:
- Shares the single-port 256x32 management DFFRAM between two requesters: the management core's DFF port (read/write) and the housekeeping SRAM read-only port.
- Sits between mgmt_core and DFFRAM, on core_clk.
- Core has priority. A starvation counter guarantees that a pending housekeeping read is served within MAX_CORE_BURST+1 cycles.

Parameters:
- AW, 8, RAM word-address width (256 words).
- DW, 32, data width.
- MAX_CORE_BURST, 4, consecutive core grants allowed while a housekeeping read is pending (1..15).

Ports:
- core_clk  in  1  system clock; all state on rising edge.
- core_rstn  in  1  reset, asynchronous, active-low.
- core_en  in  1  core access request (mgmt_soc_dff_EN).
- core_we  in  4  core byte write enables; 0 = read.
- core_addr  in  AW  core word address.
- core_wdata  in  DW  core write data.
- core_stall  out  1  core request not taken this cycle; core holds en/we/addr/wdata.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DW  core read data.
- hk_req  in  1  housekeeping read request, level; held until hk_ack.
- hk_addr  in  AW  housekeeping word address, stable while hk_req is high.
- hk_ack  out  1  one-cycle pulse; hk_rdata updated the same cycle.
- hk_rdata  out  DW  housekeeping read data, held until the next ack.
- ram_en  out  1  to DFFRAM EN.
- ram_we  out  4  to DFFRAM WE.
- ram_a  out  AW  to DFFRAM A.
- ram_di  out  DW  to DFFRAM Di.
- ram_do  in  DW  from DFFRAM Do; valid the cycle after a read EN.

Behaviour:
Reset and clocking:
- Reset is asynchronous, active-low.
- While core_rstn=0: hk_ack=0, hk_rdata=0, core_rvalid=0, starve_cnt=0, hk_busy=0, rd_owner=NONE.
- While core_rstn=0, the combinational outputs are also forced: ram_en=0, ram_we=0, core_stall=0.
- Reset mid-operation drops any outstanding housekeeping read with no ack; the requester reissues it.

Arbitration (combinational, every cycle):
- hk_elig = hk_req & ~hk_busy & ~hk_ack.
- hk_win = hk_elig & (~core_en | starve_cnt==MAX_CORE_BURST).
- core_win = core_en & ~hk_win.
- core_stall = core_en & hk_win.

RAM drive:
- hk_win: ram_en=1, ram_we=0, ram_a=hk_addr, ram_di=0.
- core_win: ram_en=1, ram_we=core_we, ram_a=core_addr, ram_di=core_wdata.
- Neither: ram_en=0, ram_we=0, ram_a and ram_di don't-care (drive 0).
- Housekeeping never writes. Both requesters are fully serialized, so there is no same-address hazard.

Starvation counter (registered, 4 bits, saturating):
- Increments when core_win & hk_elig.
- Clears on hk_win, or when hk_elig=0.

Read return (1-cycle latency, registered):
- rd_owner <= HK on hk_win; CORE on core_win with core_we==0; else NONE.
- hk_busy <= 1 on hk_win; cleared the cycle hk_ack=1.
- In the cycle after hk_win: hk_ack=1 (registered pulse, derived from rd_owner==HK) and hk_rdata=ram_do (registered capture).
- hk_ack is high exactly one cycle per grant.
- In the cycle after a core read grant: core_rvalid=1 and core_rdata=ram_do (combinational pass-through). When core_rvalid=0, core_rdata=0.
- Core writes produce no rvalid.

Back-to-back and boundary rules:
- Core may issue on consecutive cycles; throughput is 1 access/cycle when there is no contention.
- A housekeeping request held high through its ack cycle is not re-granted in the ack cycle; earliest re-grant is the cycle after ack.
- With MAX_CORE_BURST=N and continuous core_en, hk_win occurs on the (N+1)th cycle after hk_req rises: exactly one core_stall cycle per housekeeping read.
- Simultaneous hk_req rise and core_en with starve_cnt=0: core wins.
- hk_req deasserted before grant: the request is withdrawn, starve_cnt clears, and no ack is issued.
- starve_cnt never exceeds MAX_CORE_BURST.

Test Plan:
1. Reset, then idle. Core writes 0xDEADBEEF to addr 0x10 (we=4'hF), then reads 0x10 -> core_rvalid=1 one cycle after the read, core_rdata=0xDEADBEEF, core_stall=0 throughout.
2. Core idle. hk_req=1 with hk_addr=0x10 -> ram_en=1 and ram_a=0x10 in the same cycle; next cycle hk_ack=1 and hk_rdata=0xDEADBEEF. hk_req held -> next grant two cycles after the first, never in the ack cycle.
3. core_en held high for 10 cycles (reads, addrs 0..9), hk_req rises in cycle 0, MAX_CORE_BURST=4 -> core wins cycles 0-3; cycle 4 has core_stall=1 and hk_win; hk_ack in cycle 5; the core addr-4 read completes in cycle 5 with rvalid in cycle 6.
4. Byte write we=4'b0010, data 0x0000AB00, to addr 0x10 -> housekeeping read returns 0xDEADABEF.
5. Assert core_rstn=0 in the cycle after hk_win -> hk_ack stays 0, hk_rdata=0, core_rvalid=0, ram_en=0. After release, with hk_req still high -> fresh grant and ack.
6. hk_req pulsed for 2 cycles during a core burst, then dropped before its slot -> no hk_ack, no core_stall, starve_cnt back to 0.
